// File: rtl/player_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
// player_motion_ctrl_if : button/tick inputs and player status outputs
// Rev 1.0
// ============================================================================
interface player_motion_ctrl_if #(
  parameter int POS_W = 8
);
  logic [1:0]       game_tick;
  logic             button_up;
  logic             button_down;
  logic             crash;
  logic [POS_W-1:0] player_position;
  logic             game_start_pulse;
  logic             game_over_pulse;
  logic             jump_pulse;
  logic             jumping;
  logic             ducking;
  logic             game_over;

  modport master (
    output game_tick, button_up, button_down, crash,
    input  player_position, game_start_pulse, game_over_pulse, jump_pulse,
           jumping, ducking, game_over
  );

  modport slave (
    input  game_tick, button_up, button_down, crash,
    output player_position, game_start_pulse, game_over_pulse, jump_pulse,
           jumping, ducking, game_over
  );
endinterface
`default_nettype wire

// File: rtl/player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// player_motion_ctrl : dino game state machine and vertical jump physics
// Rev 1.0
// ============================================================================
module player_motion_ctrl #(
  parameter int POS_W         = 8,
  parameter int VEL_W         = 5,
  parameter int JUMP_VELOCITY = 12,
  parameter int GRAVITY       = 2,
  parameter int HOLD_GRAVITY  = 1,
  parameter int DROP_GRAVITY  = 4,
  parameter int MAX_FALL      = 15,
  parameter int RESTART_TICKS = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  player_motion_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(RESTART_TICKS + 1);
  localparam int SUM_W = POS_W + 2;
  localparam int GV_W  = VEL_W + 2;

  localparam logic signed [GV_W-1:0]  G_NORM       = GV_W'(GRAVITY);
  localparam logic signed [GV_W-1:0]  G_HOLD       = GV_W'(HOLD_GRAVITY);
  localparam logic signed [GV_W-1:0]  G_DROP       = GV_W'(DROP_GRAVITY);
  localparam logic signed [GV_W-1:0]  NEG_MAX_FALL = -GV_W'(MAX_FALL);
  localparam logic signed [VEL_W:0]   JUMP_VEL     = (VEL_W + 1)'(JUMP_VELOCITY);
  localparam logic [CNT_W-1:0]        LOCK_MAX     = CNT_W'(RESTART_TICKS);
  localparam logic [POS_W-1:0]        POS_MAX      = {POS_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUNNING   = 3'd1,
    S_JUMPING   = 3'd2,
    S_DUCKING   = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic signed [VEL_W:0] vel_q, vel_d;
  logic [CNT_W-1:0]      lock_q, lock_d;
  logic                  released_q, released_d;
  logic                  start_pulse_q, start_pulse_d;
  logic                  over_pulse_q, over_pulse_d;
  logic                  jump_pulse_q, jump_pulse_d;

  logic                    w_tick0;
  logic                    w_tick1;
  logic                    w_vel_pos;
  logic signed [GV_W-1:0]  w_grav;
  logic signed [GV_W-1:0]  w_vel_ext;
  logic signed [GV_W-1:0]  w_vel_sub;
  logic [VEL_W:0]          w_vel_next;
  logic signed [SUM_W-1:0] w_sum;
  logic                    w_land;
  logic                    w_ceil;
  logic                    w_lock_done;

  // A 2'b11 tick is treated as tick[0] alone.
  assign w_tick0 = bus.game_tick[0];
  assign w_tick1 = bus.game_tick[1] & ~bus.game_tick[0];

  assign w_vel_pos = ~vel_q[VEL_W] & (vel_q != '0);
  assign w_grav    = bus.button_down              ? G_DROP :
                     (bus.button_up && w_vel_pos) ? G_HOLD : G_NORM;
  assign w_vel_ext  = {vel_q[VEL_W], vel_q};
  assign w_vel_sub  = w_vel_ext - w_grav;
  assign w_vel_next = (w_vel_sub < NEG_MAX_FALL) ? NEG_MAX_FALL[VEL_W:0] : w_vel_sub[VEL_W:0];

  // Two guard bits: the sign bit flags landing, bit POS_W flags the ceiling.
  assign w_sum  = {2'b00, pos_q} + {{(SUM_W - VEL_W - 1){vel_q[VEL_W]}}, vel_q};
  assign w_land = w_sum[SUM_W-1] | (w_sum == '0);
  assign w_ceil = ~w_sum[SUM_W-1] & w_sum[POS_W];

  assign w_lock_done = (lock_q == LOCK_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pos_q         <= '0;
      vel_q         <= '0;
      lock_q        <= '0;
      released_q    <= 1'b0;
      start_pulse_q <= 1'b0;
      over_pulse_q  <= 1'b0;
      jump_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      vel_q         <= vel_d;
      lock_q        <= lock_d;
      released_q    <= released_d;
      start_pulse_q <= start_pulse_d;
      over_pulse_q  <= over_pulse_d;
      jump_pulse_q  <= jump_pulse_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    vel_d         = vel_q;
    lock_d        = lock_q;
    released_d    = released_q;
    start_pulse_d = 1'b0;
    over_pulse_d  = 1'b0;
    jump_pulse_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        pos_d = '0;
        vel_d = '0;
        if (w_tick0 && bus.button_up) begin
          state_d       = S_JUMPING;
          vel_d         = JUMP_VEL;
          start_pulse_d = 1'b1;
          jump_pulse_d  = 1'b1;
        end
      end

      S_RUNNING: begin
        pos_d = '0;
        vel_d = '0;
        if (w_tick0) begin
          if (bus.crash) begin
            state_d      = S_GAME_OVER;
            over_pulse_d = 1'b1;
            lock_d       = '0;
            released_d   = 1'b0;
          end else if (bus.button_up) begin
            state_d      = S_JUMPING;
            vel_d        = JUMP_VEL;
            jump_pulse_d = 1'b1;
          end else if (bus.button_down) begin
            state_d = S_DUCKING;
          end
        end
      end

      S_DUCKING: begin
        pos_d = '0;
        vel_d = '0;
        if (w_tick0) begin
          if (bus.crash) begin
            state_d      = S_GAME_OVER;
            over_pulse_d = 1'b1;
            lock_d       = '0;
            released_d   = 1'b0;
          end else if (!bus.button_down) begin
            state_d = S_RUNNING;
          end
        end
      end

      S_JUMPING: begin
        if (w_tick0) begin
          if (bus.crash) begin
            state_d      = S_GAME_OVER;
            over_pulse_d = 1'b1;
            lock_d       = '0;
            released_d   = 1'b0;
          end else begin
            vel_d = w_vel_next;
          end
        end else if (w_tick1) begin
          if (w_land) begin
            pos_d   = '0;
            vel_d   = '0;
            state_d = bus.button_down ? S_DUCKING : S_RUNNING;
          end else if (w_ceil) begin
            pos_d = POS_MAX;
            vel_d = '0;
          end else begin
            pos_d = w_sum[POS_W-1:0];
          end
        end
      end

      S_GAME_OVER: begin
        if (w_tick0) begin
          if (w_lock_done && released_q && bus.button_up) begin
            state_d       = S_RUNNING;
            start_pulse_d = 1'b1;
            pos_d         = '0;
            vel_d         = '0;
          end else begin
            if (!w_lock_done) begin
              lock_d = lock_q + CNT_W'(1);
            end
            if (!bus.button_up) begin
              released_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        pos_d   = '0;
        vel_d   = '0;
      end
    endcase
  end

  assign bus.player_position  = pos_q;
  assign bus.game_start_pulse = start_pulse_q;
  assign bus.game_over_pulse  = over_pulse_q;
  assign bus.jump_pulse       = jump_pulse_q;
  assign bus.jumping          = (state_q == S_JUMPING);
  assign bus.ducking          = (state_q == S_DUCKING);
  assign bus.game_over        = (state_q == S_GAME_OVER);

endmodule
`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// tb_player_motion_ctrl : table-driven bench for player_motion_ctrl
// Rev 1.0
// ============================================================================
module tb_player_motion_ctrl;
  localparam int POS_W = 8;

  // flag codes {jumping, ducking, game_over}; pulse codes {start, over, jump}
  localparam logic [2:0] N  = 3'b000;
  localparam logic [2:0] J  = 3'b100;
  localparam logic [2:0] D  = 3'b010;
  localparam logic [2:0] O  = 3'b001;
  localparam logic [2:0] PS = 3'b100;
  localparam logic [2:0] PO = 3'b010;
  localparam logic [2:0] PJ = 3'b001;

  typedef struct {
    logic       up;
    logic       dn;
    logic       cr;
    logic [7:0] pos;
    logic [2:0] flg;
    logic [2:0] pul;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  player_motion_ctrl_if #(.POS_W(POS_W)) ifc ();

  player_motion_ctrl #(.POS_W(POS_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  function automatic logic [2:0] flags();
    return {ifc.jumping, ifc.ducking, ifc.game_over};
  endfunction

  function automatic logic [2:0] pulses();
    return {ifc.game_start_pulse, ifc.game_over_pulse, ifc.jump_pulse};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic up, input logic dn, input logic cr,
                     input int pos, input logic [2:0] flg, input logic [2:0] pul);
    vec_t e;
    e.up  = up;
    e.dn  = dn;
    e.cr  = cr;
    e.pos = pos[7:0];
    e.flg = flg;
    e.pul = pul;
    tbl.push_back(e);
  endtask

  // One tick[0] then tick[1]; pulses are read after tick[0], the rest after tick[1].
  task automatic apply(input vec_t e, input int idx);
    logic [2:0] pul0;
    vec_t       x;
    sb.push_back(e);
    @(negedge clk);
    ifc.button_up   = e.up;
    ifc.button_down = e.dn;
    ifc.crash       = e.cr;
    ifc.game_tick   = 2'b01;
    @(negedge clk);
    pul0          = pulses();
    ifc.game_tick = 2'b10;
    @(negedge clk);
    ifc.game_tick = 2'b00;
    x = sb.pop_front();
    chk($sformatf("vec%0d pulses", idx), {29'd0, pul0}, {29'd0, x.pul});
    chk($sformatf("vec%0d pulse_width", idx), {29'd0, pulses()}, 32'd0);
    chk($sformatf("vec%0d position", idx), {24'd0, ifc.player_position}, {24'd0, x.pos});
    chk($sformatf("vec%0d flags", idx), {29'd0, flags()}, {29'd0, x.flg});
  endtask

  initial begin
    int desc_a[12] = '{22, 30, 36, 40, 42, 42, 40, 36, 30, 22, 12, 0};
    int hold_a[21] = '{23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                       76, 72, 66, 58, 48, 36, 22, 7, 0};
    int rise_a[6]  = '{22, 30, 36, 40, 42, 42};
    int drop_a[4]  = '{38, 30, 18, 3};
    int tail_a[4]  = '{18, 24, 28, 30};

    ifc.game_tick   = 2'b00;
    ifc.button_up   = 1'b0;
    ifc.button_down = 1'b0;
    ifc.crash       = 1'b0;

    // plain jump from IDLE, button released after one tick
    add(1, 0, 0, 12, J, PS | PJ);
    foreach (desc_a[i]) add(0, 0, 0, desc_a[i], (desc_a[i] == 0) ? N : J, N);
    // button held: floating ascent, apex plateau, descent to terminal speed
    add(1, 0, 0, 12, J, PJ);
    foreach (hold_a[i]) add(1, 0, 0, hold_a[i], (hold_a[i] == 0) ? N : J, N);
    // fast drop from the apex, landing into DUCKING
    add(1, 0, 0, 12, J, PJ);
    foreach (rise_a[i]) add(0, 0, 0, rise_a[i], J, N);
    foreach (drop_a[i]) add(0, 1, 0, drop_a[i], J, N);
    add(0, 1, 0, 0, D, N);
    add(1, 1, 0, 0, D, N);
    add(0, 0, 0, 0, N, N);
    add(0, 1, 0, 0, D, N);
    add(0, 0, 0, 0, N, N);
    // crash beats button_up; restart needs a release first
    add(1, 0, 1, 0, O, PO);
    repeat (6) add(1, 0, 0, 0, O, N);
    add(0, 0, 0, 0, O, N);
    add(1, 0, 0, 0, N, PS);
    // crash mid-jump freezes height; lockout boundary on 4th/5th tick
    add(1, 0, 0, 12, J, PJ);
    add(0, 0, 0, 22, J, N);
    add(0, 0, 1, 22, O, PO);
    add(0, 0, 0, 22, O, N);
    add(0, 0, 0, 22, O, N);
    add(1, 0, 0, 22, O, N);
    add(1, 0, 0, 22, O, N);
    add(1, 0, 0, 0, N, PS);
    // crash while ducking
    add(0, 1, 0, 0, D, N);
    add(0, 1, 1, 0, O, PO);
    repeat (4) add(0, 0, 0, 0, O, N);
    add(1, 0, 0, 0, N, PS);

    repeat (2) @(negedge clk);
    chk("reset position", {24'd0, ifc.player_position}, 32'd0);
    chk("reset flags", {29'd0, flags()}, 32'd0);
    chk("reset pulses", {29'd0, pulses()}, 32'd0);
    reset = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // inputs without a tick are ignored
    @(negedge clk);
    ifc.button_up   = 1'b1;
    ifc.button_down = 1'b1;
    ifc.crash       = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_tick flags", {29'd0, flags()}, 32'd0);
    chk("no_tick pulses", {29'd0, pulses()}, 32'd0);
    ifc.button_down = 1'b0;
    ifc.crash       = 1'b0;

    // 2'b11 acts as tick[0] only: start, then gravity with no position step
    ifc.game_tick = 2'b11;
    @(negedge clk);
    chk("t11 start jumping", {31'd0, ifc.jumping}, 32'd1);
    chk("t11 start jump_pulse", {31'd0, ifc.jump_pulse}, 32'd1);
    ifc.button_up = 1'b0;
    @(negedge clk);
    chk("t11 no move", {24'd0, ifc.player_position}, 32'd0);
    ifc.game_tick = 2'b10;
    @(negedge clk);
    ifc.game_tick = 2'b00;
    chk("t11 first step", {24'd0, ifc.player_position}, 32'd10);
    foreach (tail_a[i]) begin
      vec_t e;
      e.up = 1'b0; e.dn = 1'b0; e.cr = 1'b0;
      e.pos = tail_a[i][7:0]; e.flg = J; e.pul = N;
      apply(e, 100 + i);
    end

    // asynchronous reset at height 30, between clock edges
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset position", {24'd0, ifc.player_position}, 32'd0);
    chk("async reset flags", {29'd0, flags()}, 32'd0);
    chk("async reset pulses", {29'd0, pulses()}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    begin
      vec_t e;
      e.up = 1'b1; e.dn = 1'b0; e.cr = 1'b0;
      e.pos = 8'd12; e.flg = J; e.pul = PS | PJ;
      apply(e, 200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
